// File: rtl/regfile_sb_16_pkg.sv
// Shared sizing, index/data types and the hazard helper for the decode-stage register file.
package regfile_sb_16_pkg;

  localparam int unsigned REG_WIDTH = 16;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned CNT_WIDTH = 2;
  localparam int unsigned IDX_WIDTH = 3;

  typedef logic [IDX_WIDTH-1:0] reg_idx_t;
  typedef logic [REG_WIDTH-1:0] reg_data_t;
  typedef logic [CNT_WIDTH-1:0] cnt_t;

  // A used source stalls while writes are pending, unless this cycle's
  // writeback is the last outstanding one and is forwarded by the bypass.
  function automatic logic src_hazard(input logic val, input cnt_t cnt, input logic byp);
    return val && (cnt != '0) && !(byp && (cnt == cnt_t'(1)));
  endfunction

endpackage

// File: rtl/regfile_sb_16_if.sv
// Decode-side bus of the register file: two read ports, issue and writeback, status.
// master: decode stage driving indices/enables; slave: the register file.
interface regfile_sb_16_if;
  import regfile_sb_16_pkg::*;

  reg_idx_t  rd_reg1;
  logic      rd_val1;
  reg_data_t rd_data1;
  reg_idx_t  rd_reg2;
  logic      rd_val2;
  reg_data_t rd_data2;
  logic      iss_en;
  reg_idx_t  iss_reg;
  logic      wr_en;
  reg_idx_t  wr_reg;
  reg_data_t wr_data;
  logic      stall;
  logic      err;

  modport master (
    output rd_reg1, rd_val1, rd_reg2, rd_val2, iss_en, iss_reg, wr_en, wr_reg, wr_data,
    input  rd_data1, rd_data2, stall, err
  );

  modport slave (
    input  rd_reg1, rd_val1, rd_reg2, rd_val2, iss_en, iss_reg, wr_en, wr_reg, wr_data,
    output rd_data1, rd_data2, stall, err
  );

endinterface

// File: rtl/regfile_sb_16_reg16.sv
// 16-bit storage register with write enable.
// Ports: clk, rst (async active-high clear), we (load enable), d (data in), q (stored value).
module regfile_sb_16_reg16
  import regfile_sb_16_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_data_t d,
  output reg_data_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/regfile_sb_16_sb_counter.sv
// Saturating in-flight write counter for one register.
// Ports: clk, rst (async active-high clear), inc (issue), dec (writeback),
//        cnt (outstanding writes), ovf_c/unf_c (combinational overflow/underflow this cycle).
module regfile_sb_16_sb_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         ovf_c,
  output logic         unf_c
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_nxt;

  // Issue and writeback in the same cycle cancel and can never flag an error.
  always_comb begin
    cnt_nxt = cnt;
    ovf_c   = 1'b0;
    unf_c   = 1'b0;
    if (inc && !dec) begin
      if (cnt == CNT_MAX) ovf_c   = 1'b1;
      else                cnt_nxt = cnt + W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) unf_c   = 1'b1;
      else           cnt_nxt = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= cnt_nxt;
  end

endmodule

// File: rtl/regfile_sb_16.sv
// Eight-entry 16-bit register file with write-to-read bypass and in-flight scoreboard.
// Ports: clk, rst (async active-high), bus (slave side of regfile_sb_16_if):
//   rd_reg1/2, rd_val1/2 -> rd_data1/2 (zero-latency, bypassed), iss_en/iss_reg (issue),
//   wr_en/wr_reg/wr_data (writeback), stall (pending source), err (sticky + X detect).
module regfile_sb_16
  import regfile_sb_16_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  regfile_sb_16_if.slave  bus
);

  reg_data_t             q   [NUM_REGS];
  cnt_t                  cnt [NUM_REGS];
  logic [NUM_REGS-1:0]   we;
  logic [NUM_REGS-1:0]   inc;
  logic [NUM_REGS-1:0]   ovf;
  logic [NUM_REGS-1:0]   unf;
  logic                  err_q;

  // Per-register storage and scoreboard; write-enable decode lives here, not in storage.
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    assign we[i]  = bus.wr_en  && (bus.wr_reg  == reg_idx_t'(i));
    assign inc[i] = bus.iss_en && (bus.iss_reg == reg_idx_t'(i));

    regfile_sb_16_reg16 u_reg (
      .clk (clk),
      .rst (rst),
      .we  (we[i]),
      .d   (bus.wr_data),
      .q   (q[i])
    );

    regfile_sb_16_sb_counter #(.W(CNT_WIDTH)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .dec   (we[i]),
      .cnt   (cnt[i]),
      .ovf_c (ovf[i]),
      .unf_c (unf[i])
    );
  end

  logic      byp1, byp2;
  reg_data_t rd1, rd2;
  logic      haz1, haz2;
  logic      xerr;

  // Read with bypass, hazard detect on pre-edge counters, X detect on used ports.
  always_comb begin
    byp1 = bus.wr_en && (bus.wr_reg == bus.rd_reg1);
    byp2 = bus.wr_en && (bus.wr_reg == bus.rd_reg2);
    rd1  = byp1 ? bus.wr_data : q[bus.rd_reg1];
    rd2  = byp2 ? bus.wr_data : q[bus.rd_reg2];
    haz1 = src_hazard(bus.rd_val1, cnt[bus.rd_reg1], byp1);
    haz2 = src_hazard(bus.rd_val2, cnt[bus.rd_reg2], byp2);
    xerr = (bus.rd_val1 && ((^rd1) === 1'bx)) || (bus.rd_val2 && ((^rd2) === 1'bx));
  end

  // Sticky error on any counter overflow/underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 err_q <= 1'b0;
    else if ((|ovf) || (|unf)) err_q <= 1'b1;
  end

  // Outputs are forced quiet while reset is held, including the bypass path.
  assign bus.rd_data1 = rst ? '0 : rd1;
  assign bus.rd_data2 = rst ? '0 : rd2;
  assign bus.stall    = !rst && (haz1 || haz2);
  assign bus.err      = !rst && (err_q || xerr);

endmodule

// File: tb/tb_regfile_sb_16.sv
// Directed self-checking bench for regfile_sb_16.
module tb_regfile_sb_16;
  import regfile_sb_16_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_sb_16_if bus ();

  regfile_sb_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.rd_reg1 = '0; bus.rd_val1 = 1'b0;
    bus.rd_reg2 = '0; bus.rd_val2 = 1'b0;
    bus.iss_en  = 1'b0; bus.iss_reg = '0;
    bus.wr_en   = 1'b0; bus.wr_reg  = '0; bus.wr_data = '0;
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic next_cycle();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic issue(input reg_idx_t r);
    next_cycle();
    bus.iss_en = 1'b1; bus.iss_reg = r;
  endtask

  task automatic writeback(input reg_idx_t r, input reg_data_t d);
    bus.wr_en = 1'b1; bus.wr_reg = r; bus.wr_data = d;
  endtask

  task automatic read1(input reg_idx_t r);
    bus.rd_val1 = 1'b1; bus.rd_reg1 = r;
  endtask

  task automatic chk(input string tag, input reg_data_t d1, input logic st, input logic er);
    check_eq({tag, "_data1"}, bus.rd_data1, d1);
    check_eq({tag, "_stall"}, 16'(bus.stall), 16'(st));
    check_eq({tag, "_err"},   16'(bus.err),   16'(er));
  endtask

  initial begin
    checks = 0; failures = 0;
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_data2", bus.rd_data2, 16'h0000);
    chk("rst", 16'h0000, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Basic write then read of r5
    issue(3'd5);
    next_cycle(); writeback(3'd5, 16'hBEEF);
    next_cycle(); read1(3'd5); #1;
    chk("wr_r5", 16'hBEEF, 1'b0, 1'b0);

    // Same-cycle bypass on port 2
    issue(3'd2);
    next_cycle(); writeback(3'd2, 16'h1234);
    bus.rd_val2 = 1'b1; bus.rd_reg2 = 3'd2; #1;
    check_eq("byp_data2", bus.rd_data2, 16'h1234);
    check_eq("byp_stall", 16'(bus.stall), 16'h0000);

    // Hazard on r4 cleared by its only writeback
    issue(3'd4);
    next_cycle(); read1(3'd4); #1;
    chk("haz_pend", 16'h0000, 1'b1, 1'b0);
    next_cycle(); read1(3'd4); writeback(3'd4, 16'h00AA); #1;
    chk("haz_wb", 16'h00AA, 1'b0, 1'b0);
    next_cycle(); read1(3'd4); #1;
    chk("haz_after", 16'h00AA, 1'b0, 1'b0);

    // Two writes in flight to r1
    issue(3'd1);
    issue(3'd1);
    next_cycle(); read1(3'd1); #1;
    chk("mf_two", 16'h0000, 1'b1, 1'b0);
    next_cycle(); read1(3'd1); writeback(3'd1, 16'h1111); #1;
    chk("mf_wb1", 16'h1111, 1'b1, 1'b0);
    next_cycle(); read1(3'd1); #1;
    chk("mf_one", 16'h1111, 1'b1, 1'b0);
    next_cycle(); read1(3'd1); writeback(3'd1, 16'h2222);
    bus.iss_en = 1'b1; bus.iss_reg = 3'd1; #1;
    chk("mf_isswb", 16'h2222, 1'b0, 1'b0);
    next_cycle(); bus.rd_reg1 = 3'd1; #1;
    check_eq("mf_noval_stall", 16'(bus.stall), 16'h0000);
    bus.rd_val2 = 1'b1; bus.rd_reg2 = 3'd1; #1;
    check_eq("mf_p2_stall", 16'(bus.stall), 16'h0001);
    check_eq("mf_p2_data", bus.rd_data2, 16'h2222);
    next_cycle(); read1(3'd1); writeback(3'd1, 16'h3333); #1;
    chk("mf_last", 16'h3333, 1'b0, 1'b0);
    next_cycle(); read1(3'd1); #1;
    chk("mf_done", 16'h3333, 1'b0, 1'b0);

    // Overflow on r6: saturates at 3 and sets err
    issue(3'd6);
    issue(3'd6);
    issue(3'd6);
    next_cycle(); #1;
    check_eq("ovf_err_pre", 16'(bus.err), 16'h0000);
    bus.iss_en = 1'b1; bus.iss_reg = 3'd6;
    next_cycle(); read1(3'd6); writeback(3'd6, 16'h6661); #1;
    chk("ovf_wb1", 16'h6661, 1'b1, 1'b1);
    next_cycle(); read1(3'd6); writeback(3'd6, 16'h6662); #1;
    chk("ovf_wb2", 16'h6662, 1'b1, 1'b1);
    next_cycle(); read1(3'd6); writeback(3'd6, 16'h6663); #1;
    chk("ovf_wb3", 16'h6663, 1'b0, 1'b1);
    next_cycle(); read1(3'd6); #1;
    chk("ovf_sticky", 16'h6663, 1'b0, 1'b1);

    // Reset clears sticky err
    rst = 1'b1; #1;
    check_eq("rst2_err", 16'(bus.err), 16'h0000);
    next_cycle(); rst = 1'b0;

    // Underflow on r7: err set, register still written
    next_cycle(); writeback(3'd7, 16'h7777);
    next_cycle(); read1(3'd7); #1;
    chk("unf", 16'h7777, 1'b0, 1'b1);
    next_cycle(); #1;
    check_eq("unf_sticky", 16'(bus.err), 16'h0001);

    // Asynchronous reset mid-run with cnt[3]=2
    issue(3'd3);
    issue(3'd3);
    next_cycle(); read1(3'd3); #1;
    check_eq("pre_rst_stall", 16'(bus.stall), 16'h0001);
    writeback(3'd3, 16'hABCD);
    bus.rd_val2 = 1'b1; bus.rd_reg2 = 3'd5;
    rst = 1'b1; #1;
    chk("arst", 16'h0000, 1'b0, 1'b0);
    check_eq("arst_data2", bus.rd_data2, 16'h0000);
    next_cycle(); rst = 1'b0;
    next_cycle(); read1(3'd3); bus.rd_val2 = 1'b1; bus.rd_reg2 = 3'd5; #1;
    chk("post_rst_r3", 16'h0000, 1'b0, 1'b0);
    check_eq("post_rst_r5", bus.rd_data2, 16'h0000);

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
